muldiv_unit: RTL and testbench



---
 rtl/muldiv_pkg.sv | 21 ++
 rtl/muldiv_sign_fix.sv | 37 +++
 rtl/muldiv_unit.sv | 193 +++++++++++++++++++
 tb/tb_muldiv_unit.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: operation
// encodings, controller states and the divide-by-zero LO fill value.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_MULT  = 2'b01,
    OP_DIVU  = 2'b10,
    OP_DIV   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIX  = 2'b10
  } state_e;

  // LO on divide by zero; sliced down to the operand width by the user.
  localparam logic [63:0] DBZ_LO = '1;

endpackage

// File: rtl/muldiv_sign_fix.sv
// Combinational sign correction applied to the unsigned magnitude result.
// Multiply: negate the full double-width product when operand signs differ.
// Divide: negate the quotient when signs differ; remainder follows dividend.
module muldiv_sign_fix
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [1:0]       op_i,
  input  logic             sign_a_i,
  input  logic             sign_b_i,
  input  logic [WIDTH-1:0] hi_raw_i,
  input  logic [WIDTH-1:0] lo_raw_i,
  output logic [WIDTH-1:0] hi_fix_o,
  output logic [WIDTH-1:0] lo_fix_o
);

  logic [2*WIDTH-1:0] prod;

  // Select the negated form of whichever halves the signed op requires.
  always_comb begin
    hi_fix_o = hi_raw_i;
    lo_fix_o = lo_raw_i;
    prod     = {hi_raw_i, lo_raw_i};
    case (op_e'(op_i))
      OP_MULT: begin
        if (sign_a_i ^ sign_b_i) {hi_fix_o, lo_fix_o} = -prod;
      end
      OP_DIV: begin
        if (sign_a_i ^ sign_b_i) lo_fix_o = -lo_raw_i;
        if (sign_a_i)            hi_fix_o = -hi_raw_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply / restoring divide with architectural HI/LO.
// Build option: MULDIV_SIGNED_EN enables mult/div (signed) handling; without
// it op[0] is ignored and every operation is unsigned (FIX is a pass-through).
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | waiting for start; mthi/mtlo writes accepted
//   ST_CALC | one shift-add or restoring-divide step per cycle
//   ST_FIX  | sign correction, HI/LO commit, done pulse on exit
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  logic             dbz_q, dbz_d;
  logic             done_q, done_d;
  logic             dbz_out_q, dbz_out_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH-1:0] fix_hi, fix_lo;
  logic [WIDTH:0]   mul_sum, div_shift, div_diff;

`ifdef MULDIV_SIGNED_EN
  logic       sa, sb;
  logic       sign_a_q, sign_b_q;
  logic [1:0] op_q;

  assign sa    = op[0] & a[WIDTH-1];
  assign sb    = op[0] & b[WIDTH-1];
  assign abs_a = sa ? -a : a;
  assign abs_b = sb ? -b : b;

  // Operation and operand signs are captured with the operands at start.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q     <= 2'b00;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
    end else if (state_q == ST_IDLE && start) begin
      op_q     <= op;
      sign_a_q <= sa;
      sign_b_q <= sb;
    end
  end

  muldiv_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
    .op_i     (op_q),
    .sign_a_i (sign_a_q),
    .sign_b_i (sign_b_q),
    .hi_raw_i (acc_hi_q),
    .lo_raw_i (acc_lo_q),
    .hi_fix_o (fix_hi),
    .lo_fix_o (fix_lo)
  );
`else
  logic unused_op0;

  assign unused_op0 = op[0];
  assign abs_a      = a;
  assign abs_b      = b;
  assign fix_hi     = acc_hi_q;
  assign fix_lo     = acc_lo_q;
`endif

  // Next-state, datapath step and HI/LO update; hold everything by default.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    dbz_d     = dbz_q;
    opnd_d    = opnd_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    dbz_out_d = 1'b0;
    mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
    div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          is_div_d = op[1];
          cnt_d    = CNT_W'(WIDTH);
          acc_hi_d = '0;
          opnd_d   = op[1] ? abs_b : abs_a;
          acc_lo_d = op[1] ? abs_a : abs_b;
          dbz_d    = op[1] && (b == '0);
          if (op[1] && (b == '0)) begin
            // Raw dividend goes straight to HI; no iterations needed.
            acc_hi_d = a;
            acc_lo_d = DBZ_LO[WIDTH-1:0];
            state_d  = ST_FIX;
          end else begin
            state_d = ST_CALC;
          end
        end else begin
          if (hi_we) hi_d = wdata;
          if (lo_we) lo_d = wdata;
        end
      end
      ST_CALC: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          if (is_div_q) begin
            acc_hi_d = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
            acc_lo_d = {acc_lo_q[WIDTH-2:0], ~div_diff[WIDTH]};
          end else begin
            acc_hi_d = mul_sum[WIDTH:1];
            acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
          end
          if (cnt_q == CNT_W'(1)) state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        state_d = ST_IDLE;
        if (!flush) begin
          hi_d      = dbz_q ? acc_hi_q : fix_hi;
          lo_d      = dbz_q ? acc_lo_q : fix_lo;
          done_d    = 1'b1;
          dbz_out_d = dbz_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      dbz_q     <= 1'b0;
      done_q    <= 1'b0;
      dbz_out_q <= 1'b0;
      opnd_q    <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      dbz_q     <= dbz_d;
      done_q    <= done_d;
      dbz_out_q <= dbz_out_d;
      opnd_q    <= opnd_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign done        = done_q;
  assign div_by_zero = dbz_out_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit (WIDTH=32). Expected values are hand
// computed; signed-op expectations follow MULDIV_SIGNED_EN.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic         flush = 1'b0;
  logic         hi_we = 1'b0;
  logic         lo_we = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [W-1:0] wdata = '0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] hi, lo;

  int n_asserts = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .flush       (flush),
    .hi_we       (hi_we),
    .lo_we       (lo_we),
    .wdata       (wdata),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge: start is high for cycle 0, done expected at exp_lat.
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input int exp_lat, output int dcyc, output logic bok,
                        output logic pok, output logic [W-1:0] h, output logic [W-1:0] l,
                        output logic z);
    dcyc = -1; bok = 1'b1; pok = 1'b0; h = '0; l = '0; z = 1'b0;
    op = o; a = av; b = bv; start = 1'b1;
    for (int k = 1; k <= exp_lat + 4; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (k <= exp_lat && busy !== (k < exp_lat)) bok = 1'b0;
      if (done === 1'b1) begin
        dcyc = k; h = hi; l = lo; z = div_by_zero;
        break;
      end
    end
    @(negedge clk);
    pok = (done === 1'b0);
  endtask

  int           dc, ndone;
  logic         bok, pok, z;
  logic [W-1:0] h, l;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dbz", div_by_zero, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    reset_n = 1'b1;
    @(negedge clk);

    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, dc, bok, pok, h, l, z);
    chk("multu_lat", dc, 34);
    chk("multu_busy", bok, 1);
    chk("multu_pulse", pok, 1);
    chk("multu_hi", h, 32'hFFFF_FFFE);
    chk("multu_lo", l, 32'h0000_0001);
    chk("multu_dbz", z, 0);

    // Issued the cycle after the previous done: back-to-back acceptance.
    run_op(OP_MULT, 32'hFFFF_FFFD, 32'd5, 34, dc, bok, pok, h, l, z);
    chk("mult_lat", dc, 34);
`ifdef MULDIV_SIGNED_EN
    chk("mult_hi", h, 32'hFFFF_FFFF);
`else
    chk("mult_hi", h, 32'h0000_0004);
`endif
    chk("mult_lo", l, 32'hFFFF_FFF1);

    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 34, dc, bok, pok, h, l, z);
    chk("div_lat", dc, 34);
`ifdef MULDIV_SIGNED_EN
    chk("div_lo", l, 32'hFFFF_FFFD);
    chk("div_hi", h, 32'hFFFF_FFFF);
`else
    chk("div_lo", l, 32'h7FFF_FFFC);
    chk("div_hi", h, 32'h0000_0001);
`endif

    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 34, dc, bok, pok, h, l, z);
    chk("divmn_lat", dc, 34);
`ifdef MULDIV_SIGNED_EN
    chk("divmn_lo", l, 32'h8000_0000);
    chk("divmn_hi", h, 32'h0000_0000);
`else
    chk("divmn_lo", l, 32'h0000_0000);
    chk("divmn_hi", h, 32'h8000_0000);
`endif

    run_op(OP_DIVU, 32'd100, 32'd0, 2, dc, bok, pok, h, l, z);
    chk("dbz_lat", dc, 2);
    chk("dbz_busy", bok, 1);
    chk("dbz_flag", z, 1);
    chk("dbz_hi", h, 32'h0000_0064);
    chk("dbz_lo", l, 32'hFFFF_FFFF);
    chk("dbz_pulse", pok, 1);

    // Flush: multu 6*7; at cycle 10 a second start plus mthi, flush at 11.
    ndone = 0;
    op = OP_MULTU; a = 32'd6; b = 32'd7; start = 1'b1;
    for (int k = 1; k <= 45; k++) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
      start = 1'b0; hi_we = 1'b0; flush = 1'b0;
      if (k == 10) begin
        op = OP_DIVU; b = 32'd0; start = 1'b1; hi_we = 1'b1; wdata = 32'hDEAD_BEEF;
      end
      if (k == 11) begin
        chk("flush_busy_before", busy, 1);
        flush = 1'b1;
      end
      if (k == 12) chk("flush_busy_after", busy, 0);
    end
    chk("flush_no_done", ndone, 0);
    chk("flush_hi", hi, 32'h0000_0064);
    chk("flush_lo", lo, 32'hFFFF_FFFF);

    lo_we = 1'b1; wdata = 32'h0000_1234;
    @(negedge clk);
    lo_we = 1'b0;
    chk("mtlo_lo", lo, 32'h0000_1234);
    chk("mtlo_hi", hi, 32'h0000_0064);
    hi_we = 1'b1; wdata = 32'h0000_5678;
    @(negedge clk);
    hi_we = 1'b0;
    chk("mthi_hi", hi, 32'h0000_5678);

    // start with mthi in IDLE drops the write; reset at cycle 15 aborts.
    ndone = 0;
    op = OP_DIVU; a = 32'd9; b = 32'd3; start = 1'b1; hi_we = 1'b1; wdata = 32'h0000_CAFE;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      start = 1'b0; hi_we = 1'b0;
      if (done === 1'b1) ndone++;
      if (k == 1) begin
        chk("startwe_busy", busy, 1);
        chk("startwe_hi", hi, 32'h0000_5678);
      end
    end
    reset_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_hi", hi, 0);
    chk("arst_lo", lo, 0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    chk("arst_no_done", ndone, 0);
    chk("arst_idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
